// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate engine: accepts a command, applies one 1-bit
// shift/rotate per clock, then holds the result on a valid/ready port.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             busy
);

    // state  | meaning
    // IDLE   | waiting for a command, in_ready=1
    // RUN    | one 1-bit step per clock until count reaches 1
    // DONE   | result presented, waiting for out_ready
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_LSL  = 3'd0;
    localparam logic [2:0] OP_LSR  = 3'd1;
    localparam logic [2:0] OP_ASR  = 3'd2;
    localparam logic [2:0] OP_ROTL = 3'd3;
    localparam logic [2:0] OP_ROTR = 3'd4;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       op_q, op_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_err_q, out_err_d;
    logic [WIDTH-1:0] step_res;

    always_comb begin
        step_res = data_q;
        case (op_q)
            OP_LSL:  step_res = {data_q[WIDTH-2:0], 1'b0};
            OP_LSR:  step_res = {1'b0, data_q[WIDTH-1:1]};
            OP_ASR:  step_res = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            OP_ROTL: step_res = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            OP_ROTR: step_res = {data_q[0], data_q[WIDTH-1:1]};
            default: step_res = data_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        op_d       = op_q;
        count_d    = count_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d    = in_data;
                    op_d      = in_op;
                    out_err_d = (in_op > OP_ROTR);
                    // Zero-length and illegal commands bypass RUN entirely
                    if ((in_amt == '0) || (in_op > OP_ROTR)) begin
                        out_data_d = in_data;
                        state_d    = S_DONE;
                    end else begin
                        count_d = in_amt;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                data_d  = step_res;
                count_d = count_q - AMT_W'(1);
                if (count_q == AMT_W'(1)) begin
                    out_data_d = step_res;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            op_q       <= '0;
            count_q    <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            op_q       <= op_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = !in_ready;
    assign out_valid = (state_q == S_DONE);
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule
